// File: rtl/rr_onehot_mux_reg_pkg.sv
// Shared helpers for the registered round-robin one-hot output mux.
// Arbiter lock state, one-hot AND-OR reduce and pointer wrap.
package noc_mux_pkg;

    localparam int NUM_CH_DFLT = 5;
    localparam int DATA_W_DFLT = 32;
    localparam int PTR_W       = $clog2(NUM_CH_DFLT);

    // Widest channel count the helper functions accept; callers zero-extend.
    localparam int MAX_CH = 32;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic onehot_mux_f(
        input logic [MAX_CH-1:0] bits,
        input logic [MAX_CH-1:0] sel
    );
        return |(bits & sel);
    endfunction

    function automatic int rr_next_f(input int idx, input int num_ch);
        return (idx + 1 >= num_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_onehot_mux_reg_arbiter.sv
// Round-robin one-hot arbiter with optional packet lock.
// Owns the priority pointer, the lock state and the locked channel.
module rr_arbiter_onehot
    import noc_mux_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int LOCK_EN = 1,
    parameter int PTR_W   = $clog2(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_xfer,
    input  logic              i_tail,
    output logic [NUM_CH-1:0] o_grant,
    output logic [PTR_W-1:0]  o_ptr,
    output logic              o_lock
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [NUM_CH-1:0] r_lock_oh;
    logic [NUM_CH-1:0] w_lock_oh_nxt;
    logic [NUM_CH-1:0] w_rr_grant;
    logic [NUM_CH-1:0] w_grant;
    logic [PTR_W:0]    w_scan;
    logic              w_found;
    logic [PTR_W-1:0]  w_gidx;

    // Scan ptr, ptr+1, ... wrapping; the first requester wins.
    always_comb begin
        w_rr_grant = '0;
        w_found    = 1'b0;
        w_scan     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(NUM_CH)) begin
                w_scan = w_scan - (PTR_W+1)'(NUM_CH);
            end
            if (!w_found && i_req[w_scan[PTR_W-1:0]]) begin
                w_rr_grant[w_scan[PTR_W-1:0]] = 1'b1;
                w_found                        = 1'b1;
            end
        end
    end

    assign w_grant = (r_state == ARB_LOCKED) ? r_lock_oh : w_rr_grant;

    // Index encoder is control-only; the data path never sees it.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_gidx = w_gidx | PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_oh_nxt = r_lock_oh;
        if (i_xfer) begin
            w_ptr_nxt = PTR_W'(rr_next_f(int'(w_gidx), NUM_CH));
            if (LOCK_EN != 0) begin
                w_state_nxt   = i_tail ? ARB_OPEN : ARB_LOCKED;
                w_lock_oh_nxt = w_grant;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= ARB_OPEN;
            r_ptr     <= '0;
            r_lock_oh <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_oh <= w_lock_oh_nxt;
        end
    end

    assign o_grant = w_grant;
    assign o_ptr   = r_ptr;
    assign o_lock  = (r_state == ARB_LOCKED);

endmodule

// File: rtl/rr_onehot_mux_reg.sv
// Registered round-robin output mux: one-hot grant, AND-OR data mux,
// single output register with valid/ready and optional packet lock.
module rr_onehot_mux_reg
    import noc_mux_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int DATA_W  = 32,
    parameter int LOCK_EN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_tail,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_tail,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        grant,
    output logic                     sel_err
);

    localparam int CH_PTR_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]   w_grant;
    logic [CH_PTR_W-1:0] w_ptr;
    logic                w_lock;
    logic                w_slot_free;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_tail_sel;
    logic                w_multi;
    logic [DATA_W-1:0]   w_mux_data;

    logic                r_out_valid;
    logic                r_out_tail;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_sel_err;

    rr_arbiter_onehot #(
        .NUM_CH  (NUM_CH),
        .LOCK_EN (LOCK_EN),
        .PTR_W   (CH_PTR_W)
    ) u_arb (
        .i_clk   (clk),
        .i_reset (reset),
        .i_req   (in_valid),
        .i_xfer  (w_in_xfer),
        .i_tail  (w_tail_sel),
        .o_grant (w_grant),
        .o_ptr   (w_ptr),
        .o_lock  (w_lock)
    );

    // A flit moves on a side when valid and ready are both high at a rising
    // edge; the output slot accepts a new flit when empty or being drained.
    assign w_slot_free = ~r_out_valid | out_ready;
    assign in_ready    = w_grant & {NUM_CH{w_slot_free & reset}};
    assign w_in_xfer   = |(in_valid & in_ready);
    assign w_out_xfer  = r_out_valid & out_ready;

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic [NUM_CH-1:0] w_col;
        for (genvar c = 0; c < NUM_CH; c++) begin : g_col
            assign w_col[c] = in_data[c*DATA_W + b];
        end
        assign w_mux_data[b] = onehot_mux_f(MAX_CH'(w_col), MAX_CH'(w_grant));
    end

    assign w_tail_sel = onehot_mux_f(MAX_CH'(in_tail), MAX_CH'(w_grant));
    assign w_multi    = |(w_grant & (w_grant - NUM_CH'(1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_tail  <= 1'b0;
            r_out_data  <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_out_data  <= w_mux_data;
                r_out_tail  <= w_tail_sel;
                r_out_valid <= 1'b1;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_multi) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_tail  = r_out_tail;
    assign out_valid = r_out_valid;
    assign grant     = w_grant;
    assign sel_err   = r_sel_err;

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(w_grant));
    a_load_data: assert property (@(posedge clk) disable iff (!reset)
        $rose(r_out_valid) |-> (r_out_data == $past(w_mux_data)));
    a_lock_stable: assert property (@(posedge clk) disable iff (!reset)
        (w_lock && $past(w_lock)) |-> $stable(w_grant));
    a_ptr_range: assert property (@(posedge clk) disable iff (!reset)
        (int'(w_ptr) < NUM_CH));
`endif

endmodule

// File: tb/tb_rr_onehot_mux_reg.sv
// Directed bench for rr_onehot_mux_reg: one locking and one non-locking
// instance, expected flits queued per instance and checked by a monitor.
module tb_rr_onehot_mux_reg;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- stimulus signals ----------------
    logic                     sel_nl;
    logic [NUM_CH-1:0]        drv_valid;
    logic [NUM_CH-1:0]        drv_tail;
    logic [NUM_CH*DATA_W-1:0] drv_data;
    logic                     drv_ready;

    logic [NUM_CH-1:0] in_valid_l, in_valid_n, in_ready_l, in_ready_n;
    logic [NUM_CH-1:0] grant_l, grant_n;
    logic [DATA_W-1:0] out_data_l, out_data_n;
    logic              out_tail_l, out_tail_n, out_valid_l, out_valid_n;
    logic              out_ready_l, out_ready_n, sel_err_l, sel_err_n;
    logic [NUM_CH-1:0] cur_grant, cur_in_ready;

    assign in_valid_l   = sel_nl ? '0 : drv_valid;
    assign in_valid_n   = sel_nl ? drv_valid : '0;
    assign out_ready_l  = sel_nl ? 1'b1 : drv_ready;
    assign out_ready_n  = sel_nl ? drv_ready : 1'b1;
    assign cur_grant    = sel_nl ? grant_n : grant_l;
    assign cur_in_ready = sel_nl ? in_ready_n : in_ready_l;

    rr_onehot_mux_reg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LOCK_EN(1)) dut_l (
        .clk(clk), .reset(reset), .in_data(drv_data), .in_valid(in_valid_l),
        .in_tail(drv_tail), .in_ready(in_ready_l), .out_data(out_data_l),
        .out_tail(out_tail_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
        .grant(grant_l), .sel_err(sel_err_l)
    );

    rr_onehot_mux_reg #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LOCK_EN(0)) dut_n (
        .clk(clk), .reset(reset), .in_data(drv_data), .in_valid(in_valid_n),
        .in_tail(drv_tail), .in_ready(in_ready_n), .out_data(out_data_n),
        .out_tail(out_tail_n), .out_valid(out_valid_n), .out_ready(out_ready_n),
        .grant(grant_n), .sel_err(sel_err_n)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DATA_W:0] exp_q_l[$];
    logic [DATA_W:0] exp_q_n[$];
    logic [DATA_W:0] e_l, e_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid_l && out_ready_l) begin
            if (exp_q_l.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL lock_out: unexpected flit %0h, nothing queued", out_data_l);
            end else begin
                e_l = exp_q_l.pop_front();
                chk("lock_out", {out_tail_l, out_data_l}, e_l);
            end
        end
        if (out_valid_n && out_ready_n) begin
            if (exp_q_n.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL nolock_out: unexpected flit %0h, nothing queued", out_data_n);
            end else begin
                e_n = exp_q_n.pop_front();
                chk("nolock_out", {out_tail_n, out_data_n}, e_n);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drv_valid = '0;
        repeat (n) begin
            @(negedge clk);
            tick();
        end
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [DATA_W-1:0] d, input logic t);
        drv_valid[ch]               = v;
        drv_tail[ch]                = t;
        drv_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic push_l(input logic t, input logic [DATA_W-1:0] d);
        exp_q_l.push_back({t, d});
    endtask

    task automatic push_n(input logic t, input logic [DATA_W-1:0] d);
        exp_q_n.push_back({t, d});
    endtask

    // Expected grant per cycle of the ch2 packet scenario.
    logic [NUM_CH-1:0] pkt_g_l[6] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00000, 5'b00000};
    logic [NUM_CH-1:0] pkt_g_n[6] = '{5'b00100, 5'b00001, 5'b00100, 5'b00001, 5'b00100, 5'b00000};

    // ch2 sends C1,C2,C3(tail) holding each flit until accepted, with a one
    // cycle bubble after C1; ch0 keeps D0 valid throughout.
    task automatic run_pkt();
        int   k;
        int   n;
        logic bub;
        logic acc;
        k   = 0;
        n   = 0;
        bub = 1'b0;
        while (k < 3 && n < 6) begin
            set_ch(0, 1'b1, 32'hD0, 1'b1);
            set_ch(2, !bub, 32'hC1 + k, (k == 2));
            @(negedge clk);
            chk("pkt_grant", cur_grant, sel_nl ? pkt_g_n[n] : pkt_g_l[n]);
            acc = drv_valid[2] & cur_in_ready[2];
            tick();
            if (bub) begin
                bub = 1'b0;
            end else if (acc) begin
                k++;
                bub = (k == 1);
            end
            n++;
        end
        chk("pkt_done", k, 3);
        set_ch(2, 1'b0, '0, 1'b0);
        @(negedge clk);
        if (!sel_nl) chk("ptr_after_tail", dut_l.u_arb.o_ptr, 3);
        chk("pkt_after_grant", cur_grant, 5'b00001);
        tick();
        set_ch(0, 1'b0, '0, 1'b0);
    endtask

    logic [NUM_CH-1:0] s2_g[6] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    logic [DATA_W-1:0] s2_d[6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA0};

    // ---------------- main sequence ----------------
    initial begin
        reset     = 1'b0;
        sel_nl    = 1'b0;
        drv_valid = '0;
        drv_tail  = '0;
        drv_data  = '0;
        drv_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid_l, 0);
        chk("rst_lock", dut_l.u_arb.o_lock, 0);
        chk("rst_sel_err", sel_err_l, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_grant", grant_l, 0);
            chk("idle_out_valid", out_valid_l, 0);
            chk("idle_in_ready", in_ready_l, 0);
        end
        tick();

        // all five channels single-flit, full throughput
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 1'b1, 32'hA0 + i, 1'b1);
        for (int c = 0; c < 6; c++) push_l(1'b1, s2_d[c]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rr_grant", grant_l, s2_g[c]);
            if (c > 0) chk("rr_cont_valid", out_valid_l, 1);
            tick();
        end
        idle(3);

        // locked packet from ch2 against ch0
        push_l(1'b0, 32'hC1);
        push_l(1'b0, 32'hC2);
        push_l(1'b1, 32'hC3);
        push_l(1'b1, 32'hD0);
        run_pkt();
        idle(3);

        // output stall for four cycles
        push_l(1'b1, 32'hB1);
        push_l(1'b1, 32'hB3);
        set_ch(1, 1'b1, 32'hB1, 1'b1);
        set_ch(3, 1'b1, 32'hB3, 1'b1);
        @(negedge clk);
        chk("stall_first_grant", grant_l, 5'b00010);
        tick();
        set_ch(1, 1'b0, '0, 1'b0);
        drv_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready_l, 0);
            chk("stall_out_valid", out_valid_l, 1);
            chk("stall_out_data", out_data_l, 32'hB1);
            chk("stall_grant", grant_l, 5'b01000);
            chk("stall_ptr", dut_l.u_arb.o_ptr, 2);
            tick();
        end
        drv_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready_l, 5'b01000);
        tick();
        set_ch(3, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("release_out_data", out_data_l, 32'hB3);
        chk("release_out_valid", out_valid_l, 1);
        tick();
        idle(3);

        // same packet stimulus on the non-locking instance
        sel_nl = 1'b1;
        push_n(1'b1, 32'hD0);
        push_n(1'b0, 32'hC1);
        push_n(1'b1, 32'hD0);
        push_n(1'b0, 32'hC2);
        push_n(1'b1, 32'hD0);
        push_n(1'b1, 32'hC3);
        push_n(1'b1, 32'hD0);
        set_ch(0, 1'b1, 32'hD0, 1'b1);
        @(negedge clk);
        chk("nl_prime_grant", grant_n, 5'b00001);
        tick();
        run_pkt();
        idle(3);
        sel_nl = 1'b0;
        idle(1);

        // reset in the middle of a ch1 packet
        push_l(1'b0, 32'hE1);
        push_l(1'b0, 32'hE2);
        push_l(1'b1, 32'hF1);
        set_ch(1, 1'b1, 32'hE1, 1'b0);
        @(negedge clk);
        chk("mid_grant", grant_l, 5'b00010);
        tick();
        set_ch(1, 1'b1, 32'hE2, 1'b0);
        @(negedge clk);
        chk("mid_locked_ready", in_ready_l, 5'b00010);
        tick();
        reset = 1'b0;
        set_ch(1, 1'b1, 32'hE3, 1'b1);
        set_ch(3, 1'b1, 32'hF3, 1'b1);
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready_l, 0);
        tick();
        reset = 1'b1;
        set_ch(1, 1'b1, 32'hF1, 1'b1);
        @(negedge clk);
        chk("post_rst_out_valid", out_valid_l, 0);
        chk("post_rst_lock", dut_l.u_arb.o_lock, 0);
        chk("post_rst_ptr", dut_l.u_arb.o_ptr, 0);
        chk("post_rst_grant", grant_l, 5'b00010);
        tick();
        idle(4);

        chk("lock_q_empty", exp_q_l.size(), 0);
        chk("nolock_q_empty", exp_q_n.size(), 0);
        chk("final_sel_err_l", sel_err_l, 0);
        chk("final_sel_err_n", sel_err_n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: sequence did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
